neuron_accumulate: RTL and testbench

- Upstream neighbour of the sigmoid activation stage.
- Sums a stream of float_24_8 products into one neuron pre-activation value, then adds a bias.
- Presents the result on a valid/ready output; it is normally wired to stage_st_data_out_pre.
- Uses one shared single-cycle float adder and a 3-state FSM. Only one dot product is in flight at a time.

---
 rtl/neuron_accumulate.sv | 198 +++++++++++++++++++
 tb/tb_neuron_accumulate.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/neuron_accumulate.sv
// neuron_accumulate: sums a stream of float_24_8 products into one neuron
// pre-activation value, adds a bias, and presents the result on a
// valid/ready output. A single shared combinational float adder serves both
// the product beats and the bias. Only one dot product is in flight at a time.
module neuron_accumulate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [31:0]      bias_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_BIAS = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // float_24_8 add: flush zero-exponent operands to +0, truncate shifted-out
  // bits, saturate on overflow and flush underflow to +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, el, es, d;
    logic [23:0] ma, mb, ml, ms, msh, mdiff, mnorm;
    logic [24:0] msum;
    logic        sa, sb, sl, ss, found;
    logic [4:0]  lz;
    logic signed [9:0] er;
    logic [31:0] res;
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    // Order operands by magnitude so the subtraction never goes negative.
    if ({ea, ma} >= {eb, mb}) begin
      el = ea; ml = ma; sl = sa;
      es = eb; ms = mb; ss = sb;
    end else begin
      el = eb; ml = mb; sl = sb;
      es = ea; ms = ma; ss = sa;
    end
    d   = el - es;
    msh = (d >= 8'd25) ? 24'd0 : (ms >> d);
    msum  = 25'd0;
    mdiff = 24'd0;
    lz    = 5'd0;
    found = 1'b0;
    if (sl == ss) begin
      msum = {1'b0, ml} + {1'b0, msh};
      if (msum[24]) begin
        mnorm = msum[24:1];
        er    = $signed({2'b00, el}) + 10'sd1;
      end else begin
        mnorm = msum[23:0];
        er    = $signed({2'b00, el});
      end
    end else begin
      mdiff = ml - msh;
      for (int i = 23; i >= 0; i--) begin
        if (!found) begin
          if (mdiff[i]) begin
            found = 1'b1;
          end else begin
            lz = lz + 5'd1;
          end
        end else begin
          found = 1'b1;
        end
      end
      mnorm = mdiff << lz;
      er    = $signed({2'b00, el}) - $signed({5'd0, lz});
    end
    if (mnorm == 24'd0) begin
      res = 32'h0000_0000;
    end else if (er > 10'sd254) begin
      res = {sl, 31'h7F7F_FFFF};
    end else if (er <= 10'sd0) begin
      res = 32'h0000_0000;
    end else begin
      res = {sl, er[7:0], mnorm[22:0]};
    end
    return res;
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_acc;
  logic [31:0]        r_bias;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               w_accept;
  logic [31:0]        w_addend;
  logic [31:0]        w_sum;

  assign w_accept = in_valid && r_in_ready;
  assign w_addend = (r_state == ST_BIAS) ? r_bias : in_data;
  assign w_sum    = fadd(r_acc, w_addend);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  // State register; in_ready is registered alongside from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ACC;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == ST_ACC);
    end
  end

  // Next-state decode: last beat -> BIAS -> HOLD -> handshake -> ACC.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_accept && in_last) begin
          w_next_state = ST_BIAS;
        end else begin
          w_next_state = ST_ACC;
        end
      end
      ST_BIAS: begin
        w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_next_state = ST_ACC;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_ACC;
      end
    endcase
  end

  // Datapath: accumulate beats, add bias, hold the result until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= 32'h0000_0000;
      r_bias      <= 32'h0000_0000;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_count <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (in_last) begin
              r_bias <= bias_data;
            end
          end
        end
        ST_BIAS: begin
          r_acc       <= w_sum;
          r_out_data  <= w_sum;
          r_out_count <= r_cnt;
          r_out_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= 32'h0000_0000;
            r_cnt       <= '0;
          end
        end
        default: begin
          r_acc       <= 32'h0000_0000;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulate.sv
// Directed testbench for neuron_accumulate. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
module tb_neuron_accumulate;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] bias_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  neuron_accumulate #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias_data (bias_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat at a falling edge; it is taken on the next rising edge.
  task automatic beat(input logic [31:0] d, input logic last, input logic [31:0] b);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    bias_data = b;
    chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one falling edge after the last beat: checks BIAS cycle, the
  // result two cycles after the last accept, then completes the handshake.
  task automatic result(input string tag, input logic [31:0] exp_d, input logic [31:0] exp_c);
    chk({tag, "_bias_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_bias_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_count"}, {16'd0, out_count}, exp_c);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    bias_data = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", {16'd0, out_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // 1.0 + 2.0 + 0.5 + bias 0 = 3.5
    beat(32'h3F80_0000, 1'b0, 32'd0);
    beat(32'h4000_0000, 1'b0, 32'd0);
    beat(32'h3F00_0000, 1'b1, 32'h0000_0000);
    result("sum35", 32'h4060_0000, 32'd3);

    // Same beats, bias -3.5 -> exact cancellation to +0
    beat(32'h3F80_0000, 1'b0, 32'd0);
    beat(32'h4000_0000, 1'b0, 32'd0);
    beat(32'h3F00_0000, 1'b1, 32'hC060_0000);
    result("cancel", 32'h0000_0000, 32'd3);

    // Overflow saturates
    beat(32'h7F00_0000, 1'b0, 32'd0);
    beat(32'h7F00_0000, 1'b1, 32'h0000_0000);
    result("sat", 32'h7F7F_FFFF, 32'd2);

    // 1.0 + 2^-24 truncates back to 1.0
    beat(32'h3F80_0000, 1'b1, 32'h3380_0000);
    result("trunc", 32'h3F80_0000, 32'd1);

    // Denormal flushed to zero
    beat(32'h0040_0000, 1'b1, 32'h0000_0000);
    result("denorm", 32'h0000_0000, 32'd1);

    // Result held with out_ready low while upstream keeps a beat waiting
    beat(32'h3F80_0000, 1'b1, 32'h0000_0000);
    chk("hold_bias_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;
    in_last   = 1'b1;
    bias_data = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", out_data, 32'h3F80_0000);
      chk("hold_count", {16'd0, out_count}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    result("after_hold", 32'h4000_0000, 32'd1);

    // Reset in the middle of a dot product
    beat(32'h3F80_0000, 1'b0, 32'd0);
    beat(32'h3F80_0000, 1'b0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_count", {16'd0, out_count}, 32'd0);
    beat(32'h4000_0000, 1'b1, 32'h3F80_0000);
    result("after_rst", 32'h4040_0000, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
